// File: rtl/lcd_frame_arb_pkg.sv
// Shared types and constants for the LCD frame-level display arbiter.
// Used by lcd_frame_arb and lcd_rr_pick.
package lcd_frame_arb_pkg;

    localparam int NUM_SRC = 3;
    localparam int RGB_W   = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } arb_state_t;

    // Round-robin start index for the search after a one-hot owner.
    function automatic logic [1:0] rr_after(input logic [NUM_SRC-1:0] oh);
        if (oh[0]) return 2'd1;
        if (oh[1]) return 2'd2;
        return 2'd0;
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Round-robin selector: returns the first set request at or after index ptr,
// wrapping around, as a one-hot vector (all-zero when nothing requests).
module lcd_rr_pick
    import lcd_frame_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_SRC-1:0] win
);

    logic [NUM_SRC-1:0] rot;
    logic [NUM_SRC-1:0] rot_win;

    always_comb begin
        // Rotate so that rot[0] is the source at ptr, then fixed priority.
        case (ptr)
            2'd1:    rot = {req[0], req[2], req[1]};
            2'd2:    rot = {req[1], req[0], req[2]};
            default: rot = req;
        endcase

        rot_win = '0;
        if (rot[0])      rot_win = 3'b001;
        else if (rot[1]) rot_win = 3'b010;
        else if (rot[2]) rot_win = 3'b100;

        case (ptr)
            2'd1:    win = {rot_win[1], rot_win[0], rot_win[2]};
            2'd2:    win = {rot_win[0], rot_win[2], rot_win[1]};
            default: win = rot_win;
        endcase
    end

endmodule

// File: rtl/lcd_frame_arb.sv
// Frame-granular arbiter choosing which of three sources drives the LCD.
// Define LCD_FRAME_ARB_BLANK_EN to insert one blank frame between owners.
module lcd_frame_arb
    import lcd_frame_arb_pkg::*;
#(
    parameter int               HOLD_FRAMES = 4,
    parameter int               H_VALID     = 800,
    parameter int               V_VALID     = 480,
    parameter logic [RGB_W-1:0] BLANK_COLOR = 24'h000000
) (
    input  logic               clk_in,
    input  logic               sys_rst_n,
    input  logic               data_req,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic [NUM_SRC-1:0] req,
    input  logic [RGB_W-1:0]   src_data0,
    input  logic [RGB_W-1:0]   src_data1,
    input  logic [RGB_W-1:0]   src_data2,
    output logic [NUM_SRC-1:0] grant,
    output logic [RGB_W-1:0]   pix_data,
    output logic               frame_tick,
    output arb_state_t         state_dbg
);

    localparam logic [7:0]  HOLD_SAT = 8'(HOLD_FRAMES);
    localparam logic [10:0] H_LIM    = 11'(H_VALID);
    localparam logic [10:0] V_LIM    = 11'(V_VALID);

    arb_state_t         state, state_n;
    logic [NUM_SRC-1:0] owner, owner_n;
    logic [1:0]         ptr, ptr_n;
    logic [7:0]         hold, hold_n;
    logic [NUM_SRC-1:0] pick;
    logic [NUM_SRC-1:0] grant_n;
    logic [RGB_W-1:0]   pix_n;
    logic               frame_start;
    logic               owner_req;
    logic               in_range;

    // data_req is a one-way strobe with no backpressure: every request in
    // cycle n is answered on pix_data in cycle n+1, nothing is ever stalled.
    assign frame_start = data_req && (pix_x == 10'd0) && (pix_y == 10'd0);
    assign owner_req   = |(req & owner);
    assign grant       = (state == OWN) ? owner : '0;
    assign state_dbg   = state;

    lcd_rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick)
    );

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        hold_n  = hold;
        if (frame_start) begin
            case (state)
                IDLE: begin
                    if (|pick) begin
                        state_n = OWN;
                        owner_n = pick;
                        ptr_n   = rr_after(pick);
                        hold_n  = 8'd1;
                    end
                end
                OWN: begin
                    // An owner that stopped requesting is released early.
                    if (!owner_req || (hold == HOLD_SAT)) begin
                        if (pick == '0) begin
                            state_n = IDLE;
                            hold_n  = '0;
                        end else if (pick != owner) begin
`ifdef LCD_FRAME_ARB_BLANK_EN
                            state_n = SWITCH;
                            hold_n  = '0;
`else
                            owner_n = pick;
                            ptr_n   = rr_after(pick);
                            hold_n  = 8'd1;
`endif
                        end
                    end else begin
                        hold_n = hold + 8'd1;
                    end
                end
`ifdef LCD_FRAME_ARB_BLANK_EN
                SWITCH: begin
                    if (|pick) begin
                        state_n = OWN;
                        owner_n = pick;
                        ptr_n   = rr_after(pick);
                        hold_n  = 8'd1;
                    end else begin
                        state_n = IDLE;
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // The frame-start pixel already belongs to the newly granted owner.
    always_comb begin
        grant_n  = (state_n == OWN) ? owner_n : '0;
        in_range = ({1'b0, pix_x} < H_LIM) && ({1'b0, pix_y} < V_LIM);
        pix_n    = BLANK_COLOR;
        if (data_req && in_range) begin
            case (grant_n)
                3'b001:  pix_n = src_data0;
                3'b010:  pix_n = src_data1;
                3'b100:  pix_n = src_data2;
                default: pix_n = BLANK_COLOR;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            ptr        <= '0;
            hold       <= '0;
            pix_data   <= BLANK_COLOR;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            ptr        <= ptr_n;
            hold       <= hold_n;
            pix_data   <= pix_n;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_lcd_frame_arb.sv
// Directed, table-driven bench for lcd_frame_arb with default parameters.
// Expectations follow LCD_FRAME_ARB_BLANK_EN when the bench is built with it.
module tb_lcd_frame_arb;
    import lcd_frame_arb_pkg::*;

    localparam int BLANK = 3;

    logic        clk_in;
    logic        sys_rst_n;
    logic        data_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [2:0]  req;
    logic [23:0] src_data0, src_data1, src_data2;
    logic [2:0]  grant;
    logic [23:0] pix_data;
    logic        frame_tick;
    arb_state_t  state_dbg;

    lcd_frame_arb dut (
        .clk_in     (clk_in),
        .sys_rst_n  (sys_rst_n),
        .data_req   (data_req),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .req        (req),
        .src_data0  (src_data0),
        .src_data1  (src_data1),
        .src_data2  (src_data2),
        .grant      (grant),
        .pix_data   (pix_data),
        .frame_tick (frame_tick),
        .state_dbg  (state_dbg)
    );

    // Sources return coordinate-dependent colours so wrong muxing shows up.
    assign src_data0 = {8'hA0, 6'b0, pix_x};
    assign src_data1 = {8'hB1, 6'b0, pix_y};
    assign src_data2 = {8'hC2, pix_x[7:0] ^ pix_y[7:0], 8'h5A};

    function automatic logic [23:0] model_pix(int s, logic [9:0] x, logic [9:0] y);
        case (s)
            0:       return {8'hA0, 6'b0, x};
            1:       return {8'hB1, 6'b0, y};
            2:       return {8'hC2, x[7:0] ^ y[7:0], 8'h5A};
            default: return 24'h000000;
        endcase
    endfunction

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst_n;
        logic       dreq;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] rq;
        logic [2:0] egrant;
        int         esrc;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(logic rst_n, logic dreq, int x, int y,
                                logic [2:0] rq, logic [2:0] eg, int esrc);
        vec_t v;
        v.rst_n  = rst_n;
        v.dreq   = dreq;
        v.x      = 10'(x);
        v.y      = 10'(y);
        v.rq     = rq;
        v.egrant = eg;
        v.esrc   = esrc;
        vq.push_back(v);
    endfunction

    // scoreboard check
    task automatic check(string name, int idx, logic [23:0] act, logic [23:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    // driver
    task automatic apply(int idx, vec_t v);
        logic etick;
        @(negedge clk_in);
        sys_rst_n = v.rst_n;
        data_req  = v.dreq;
        pix_x     = v.x;
        pix_y     = v.y;
        req       = v.rq;
        @(posedge clk_in);
        #1;
        etick = v.rst_n && v.dreq && (v.x == 10'd0) && (v.y == 10'd0);
        n_vec++;
        check("grant", idx, {21'b0, grant}, {21'b0, v.egrant});
        check("pix_data", idx, pix_data, model_pix(v.esrc, v.x, v.y));
        check("frame_tick", idx, {23'b0, frame_tick}, {23'b0, etick});
    endtask

    initial begin
        int k;
        logic [2:0] g;
        int s;
        int seen;

        sys_rst_n = 1'b0;
        data_req  = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        req       = '0;

        // single source, range limits, early drop
        add(0, 1, 5, 5, 3'b001, 3'b000, BLANK);
        add(0, 0, 0, 0, 3'b001, 3'b000, BLANK);
        add(1, 1, 10, 10, 3'b001, 3'b000, BLANK);
        add(1, 1, 0, 0, 3'b001, 3'b001, 0);
        add(1, 1, 1, 0, 3'b001, 3'b001, 0);
        add(1, 1, 799, 479, 3'b001, 3'b001, 0);
        add(1, 0, 2, 0, 3'b001, 3'b001, BLANK);
        add(1, 1, 800, 5, 3'b001, 3'b001, BLANK);
        add(1, 1, 5, 480, 3'b001, 3'b001, BLANK);
        add(1, 1, 0, 0, 3'b001, 3'b001, 0);
        add(1, 1, 3, 0, 3'b000, 3'b001, 0);
        add(1, 1, 0, 0, 3'b000, 3'b000, BLANK);
        add(1, 1, 4, 4, 3'b000, 3'b000, BLANK);

        // constant contention from reset
        add(0, 1, 9, 9, 3'b111, 3'b000, BLANK);
`ifdef LCD_FRAME_ARB_BLANK_EN
        for (int f = 0; f < 16; f++) begin
            if (f % 5 == 4) begin
                g = 3'b000;
                s = BLANK;
            end else begin
                s = (f / 5) % 3;
                g = 3'b001 << s;
            end
            add(1, 1, 0, 0, 3'b111, g, s);
            add(1, 1, 7, f, 3'b111, g, s);
        end
`else
        for (int f = 0; f < 13; f++) begin
            s = (f / 4) % 3;
            g = 3'b001 << s;
            add(1, 1, 0, 0, 3'b111, g, s);
            add(1, 1, 7, f, 3'b111, g, s);
        end
`endif

        // reset in the middle of a frame owned by source 2
        add(0, 0, 0, 0, 3'b000, 3'b000, BLANK);
        add(1, 1, 0, 0, 3'b100, 3'b100, 2);
        add(1, 1, 400, 240, 3'b100, 3'b100, 2);
        add(0, 1, 400, 240, 3'b100, 3'b000, BLANK);
        add(1, 1, 10, 10, 3'b111, 3'b000, BLANK);
        add(1, 1, 0, 0, 3'b111, 3'b001, 0);

        // owner saturates, keeps grant alone, then hands over to source 1
        add(1, 1, 0, 0, 3'b001, 3'b001, 0);
        add(1, 1, 0, 0, 3'b001, 3'b001, 0);
        add(1, 1, 0, 0, 3'b001, 3'b001, 0);
        add(1, 1, 0, 0, 3'b001, 3'b001, 0);
`ifdef LCD_FRAME_ARB_BLANK_EN
        add(1, 1, 0, 0, 3'b010, 3'b000, BLANK);
        add(1, 1, 20, 20, 3'b010, 3'b000, BLANK);
`else
        add(1, 1, 0, 0, 3'b010, 3'b010, 1);
        add(1, 1, 20, 20, 3'b010, 3'b010, 1);
`endif
        add(1, 1, 0, 0, 3'b010, 3'b010, 1);
        add(1, 1, 21, 21, 3'b010, 3'b010, 1);

        foreach (vq[i]) apply(i, vq[i]);

        // frame_tick latency with a bounded wait, then release to IDLE
        @(negedge clk_in);
        data_req = 1'b1;
        pix_x    = '0;
        pix_y    = '0;
        req      = 3'b000;
        seen     = 0;
        for (k = 1; k <= 4; k++) begin
            @(posedge clk_in);
            #1;
            if (frame_tick) begin
                seen = k;
                break;
            end
            @(negedge clk_in);
            data_req = 1'b0;
        end
        n_vec++;
        check("tick_latency", n_vec, 24'(seen), 24'd1);
        n_vec++;
        check("release_grant", n_vec, {21'b0, grant}, 24'd0);
        n_vec++;
        check("release_state", n_vec, {22'b0, state_dbg}, {22'b0, IDLE});
        @(negedge clk_in);
        data_req = 1'b0;
        @(posedge clk_in);
        #1;
        n_vec++;
        check("tick_clear", n_vec, {23'b0, frame_tick}, 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_frame_arb.md
LCD_FRAME_ARB -- requirements
Module: lcd_frame_arb

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 4, minimum frames a grant is held before re-arbitration (range 1..255).
REQ-002 SHALL have parameter H_VALID, default 800, active pixels per line.
REQ-003 SHALL have parameter V_VALID, default 480, active lines per frame.
REQ-004 SHALL have parameter BLANK_COLOR, default 24'h000000, pixel value output when no source owns the display.
REQ-005 SHALL have port clk_in  input  1  pixel clock (33 MHz domain); the only clock.
REQ-006 SHALL have port sys_rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port data_req  input  1  pixel request from the LCD timing controller.
REQ-008 SHALL have port pix_x  input  10  requested pixel column.
REQ-009 SHALL have port pix_y  input  10  requested pixel row.
REQ-010 SHALL have port req  input  3  per-source display-ownership request, level-sensitive.
REQ-011 SHALL have ports src_data0, src_data1, src_data2  input  24 each  source RGB888 for the current pix_x/pix_y.
REQ-012 SHALL have port grant  output  3  one-hot owner; all-zero = no owner.
REQ-013 SHALL have port pix_data  output  24  arbitrated RGB888 to the timing controller.
REQ-014 SHALL have port frame_tick  output  1  one-cycle pulse at each frame start.

Function
REQ-015 Frame start SHALL be detected as data_req=1 with pix_x=0 and pix_y=0; frame_tick SHALL assert in the following cycle.
REQ-016 States SHALL be IDLE (no owner), OWN (grant held), SWITCH (see REQ-026); grant and owner SHALL change only on a frame start.
REQ-017 IDLE->OWN on a frame start with any req bit set; winner chosen round-robin, search starting at the index after the last owner (index 0 after reset).
REQ-018 In OWN, a hold counter SHALL count frame starts; on reaching HOLD_FRAMES it SHALL saturate.
REQ-019 In OWN at a frame start with hold saturated: if another source requests, the next round-robin requester SHALL win; if only the owner requests, the owner SHALL keep grant; if none request, go to IDLE.
REQ-020 Owner dropping req before hold saturates SHALL NOT release grant; the release is evaluated at the next frame start regardless of the hold count.
REQ-021 Simultaneous requests SHALL resolve strictly round-robin; no source may win twice in a row while another requests at every frame start.
REQ-022 pix_data SHALL be registered: when data_req=1 in cycle n, pix_data in cycle n+1 = src_dataK of the owner K, or BLANK_COLOR in IDLE/SWITCH; pix_data SHALL be BLANK_COLOR whenever data_req was 0 in cycle n.
REQ-023 pix_x >= H_VALID or pix_y >= V_VALID with data_req=1 SHALL yield BLANK_COLOR.
REQ-024 Hold counter SHALL reset to 1 on every grant change.

Reset
REQ-025 With sys_rst_n=0 at a clk_in edge: state IDLE, grant=3'b000, pix_data=BLANK_COLOR, frame_tick=0, hold counter 0, round-robin pointer 0; a reset mid-frame SHALL abandon the frame and re-arbitrate at the next frame start.

Configuration
REQ-026 Macro LCD_FRAME_ARB_BLANK_EN defined: every owner change between two different sources SHALL pass through SWITCH for exactly one frame (grant=000, BLANK_COLOR output), then enter OWN with the winner chosen at the SWITCH-ending frame start.
REQ-027 Macro not defined: the SWITCH state SHALL NOT be built; owner changes go directly OWN->OWN.

Structure
REQ-028 A shared package SHALL hold the state encoding type (IDLE/OWN/SWITCH), the source count constant (3) and the RGB888 width constant (24).
REQ-029 A single sub-module lcd_rr_pick SHALL implement the round-robin selector (request vector + pointer -> one-hot winner); all state and the data path remain in lcd_frame_arb.

Verification
REQ-030 Single source: req=001 from reset, HOLD_FRAMES=4 -> grant=001 after the first frame start; pix_data equals src_data0 one cycle after each data_req.
REQ-031 Contention: req=111 constant -> grant sequence 001,010,100,001, each held exactly 4 frames.
REQ-032 Early drop: req=001 then 000 in frame 2 -> grant 001 until the frame-3 start, then 000 and pix_data=24'h000000.
REQ-033 Blank switch (macro defined): owner 001 saturated, req=010 -> one frame of grant=000 and BLANK_COLOR, then grant=010; macro undefined -> grant=010 directly.
REQ-034 Reset mid-frame: assert sys_rst_n=0 at pixel (400,240) while grant=100 -> next cycle grant=000, pix_data=BLANK_COLOR; after release, grant=001 at the first frame start with req=111.
REQ-035 Out-of-range: pix_x=800 with data_req=1 and owner 001 -> pix_data=BLANK_COLOR next cycle.
